// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_ctrl
//  Purpose  : Multi-cycle radix-2 restoring integer divider with sequencing
//             FSM for DIV.W / MOD.W / DIV.WU / MOD.WU in the EX stage.
//             One quotient bit per cycle, DATA_W iterations. Raises
//             stallreq_o while a divide is pending and abandons work on
//             annul_i.
//  Options  : DIV_EARLY_OUT_EN - when defined, |dividend| < |divisor| skips
//             the iteration and completes in a single cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              annul_i,
    input  logic              signed_i,
    input  logic              mod_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              ready_o,
    output logic              div_zero_o,
    output logic              stallreq_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_dvd;      // dividend bits shifting out, quotient bits shifting in
    logic [DATA_W-1:0]   r_dsr;      // divisor magnitude
    logic [DATA_W-1:0]   r_rem;      // partial remainder (always < divisor)
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_mod;
    logic [DATA_W-1:0]   r_result;
    logic                r_div_zero;

    logic                w_sign1;
    logic                w_sign2;
    logic [DATA_W-1:0]   w_abs1;
    logic [DATA_W-1:0]   w_abs2;
    logic                w_divisor_zero;
    logic                w_early;
    logic [DATA_W:0]     w_shift;
    logic                w_ge;
    logic [DATA_W-1:0]   w_diff;
    logic [DATA_W-1:0]   w_rem_next;
    logic [DATA_W-1:0]   w_quo_next;
    logic [DATA_W-1:0]   w_quo_final;
    logic [DATA_W-1:0]   w_rem_final;

    // Operand preparation at accept: magnitudes and sign bookkeeping.
    // The magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude, so no special case is needed.
    assign w_sign1        = signed_i & opdata1_i[DATA_W-1];
    assign w_sign2        = signed_i & opdata2_i[DATA_W-1];
    assign w_abs1         = w_sign1 ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_abs2         = w_sign2 ? (~opdata2_i + 1'b1) : opdata2_i;
    assign w_divisor_zero = (opdata2_i == '0);

`ifdef DIV_EARLY_OUT_EN
    assign w_early = ~w_divisor_zero & (w_abs1 < w_abs2);
`else
    assign w_early = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, trial-subtract.
    // The shifted value can reach DATA_W+1 bits, so the compare is full
    // width; the kept difference always fits DATA_W bits.
    assign w_shift     = {r_rem, r_dvd[DATA_W-1]};
    assign w_ge        = (w_shift >= {1'b0, r_dsr});
    assign w_diff      = w_shift[DATA_W-1:0] - r_dsr;
    assign w_rem_next  = w_ge ? w_diff : w_shift[DATA_W-1:0];
    assign w_quo_next  = {r_dvd[DATA_W-2:0], w_ge};
    assign w_quo_final = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_rem_final = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

    // Sequencing FSM with datapath registers and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_rem      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_mod      <= 1'b0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
        end else if (annul_i) begin
            r_state    <= S_IDLE;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_mod   <= mod_i;
                        r_neg_q <= w_sign1 ^ w_sign2;
                        r_neg_r <= w_sign1;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_dsr   <= w_abs2;
                        if (w_divisor_zero) begin
                            // Keep the raw dividend: it is the remainder result.
                            r_dvd   <= opdata1_i;
                            r_state <= S_DIVZERO;
                        end else if (w_early) begin
                            r_dvd    <= w_abs1;
                            r_result <= mod_i ? opdata1_i : '0;
                            r_state  <= S_END;
                        end else begin
                            r_dvd   <= w_abs1;
                            r_state <= S_ON;
                        end
                    end
                end
                S_DIVZERO: begin
                    r_result   <= r_mod ? r_dvd : '1;
                    r_div_zero <= 1'b1;
                    r_state    <= S_END;
                end
                S_ON: begin
                    r_dvd <= w_quo_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST_ITER) begin
                        r_result <= r_mod ? w_rem_final : w_quo_final;
                        r_state  <= S_END;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        r_div_zero <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result_o   = r_result;
    assign div_zero_o = r_div_zero;
    assign ready_o    = (r_state == S_END);
    assign busy_o     = (r_state != S_IDLE);
    assign stallreq_o = start_i & ~ready_o & ~annul_i;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_ctrl
//  Purpose  : Self-checking bench for div_ctrl. Directed operations push the
//             expected result, divide-by-zero flag and completion cycle into
//             a scoreboard; a monitor compares on each rising ready_o.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic        mod_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        div_zero_o;
    logic        stallreq_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    typedef struct {
        logic [31:0] res;
        logic        dz;
        int          when;
    } exp_t;

    exp_t sb[$];

    div_ctrl #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .mod_i      (mod_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .div_zero_o (div_zero_o),
        .stallreq_o (stallreq_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: the interval after posedge k is cycle k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: each rising ready_o must match the oldest expected entry.
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        if (ready_o === 1'b1 && prev_ready !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: ready_o rose with empty scoreboard (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result_o, e.res);
                check("div_zero", {31'b0, div_zero_o}, {31'b0, e.dz});
                check("ready_cycle", cyc, e.when);
            end
        end
        prev_ready = ready_o;
    end

    // Issue one operation, hold start until ready, then release and confirm
    // the return to IDLE. Inputs are scrambled after accept to prove they
    // were latched.
    task automatic run_op(input logic s, input logic m, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_dz, input int lat);
        int t;
        int n;
        exp_t e;
        @(posedge clk); #1;
        signed_i = s; mod_i = m; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        t = cyc;
        e.res = exp_res; e.dz = exp_dz; e.when = t + lat;
        sb.push_back(e);
        #1 check("stall_at_start", {31'b0, stallreq_o}, 32'd1);
        @(posedge clk); #1;
        signed_i = ~s; mod_i = ~m; opdata1_i = $urandom; opdata2_i = $urandom;
        n = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (ready_o !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: ready_o still 0 after 100 cycles, expected by cycle %0d", t + lat);
        end else begin
            check("stall_released", {31'b0, stallreq_o}, 32'd0);
        end
        @(posedge clk); #1;
        check("end_hold", result_o, exp_res);
        start_i = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", {31'b0, busy_o}, 32'd0);
        check("idle_ready", {31'b0, ready_o}, 32'd0);
    endtask

    initial begin
        int t;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0; mod_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result_o, 32'd0);
        check("rst_ready", {31'b0, ready_o}, 32'd0);
        check("rst_div_zero", {31'b0, div_zero_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        rst = 1'b0;

        //     signed mod  dividend       divisor        expected       dz   latency
        run_op(1'b0, 1'b0, 32'd100,       32'd7,         32'd14,        1'b0, 33);
        run_op(1'b1, 1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1'b0, 33);
        run_op(1'b1, 1'b0, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0, 33);
        run_op(1'b1, 1'b0, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  1'b0, 33);
        run_op(1'b1, 1'b1, 32'd7,         32'hFFFFFFFE,  32'd1,         1'b0, 33);
        run_op(1'b1, 1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0, 33);
        run_op(1'b1, 1'b1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b0, 33);
        run_op(1'b0, 1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  1'b0, 33);
        run_op(1'b1, 1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  1'b1, 2);
        run_op(1'b0, 1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  1'b1, 2);
        run_op(1'b0, 1'b1, 32'd5,         32'd0,         32'd5,         1'b1, 2);

        // Flush mid-divide: DIV.W 1000/3 started at t, annul at t+10.
        @(posedge clk); #1;
        signed_i = 1'b1; mod_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        t = cyc;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("annul_cycle", cyc, t + 10);
        check("busy_before_annul", {31'b0, busy_o}, 32'd1);
        annul_i = 1'b1;
        #1 check("stall_under_annul", {31'b0, stallreq_o}, 32'd0);
        start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        check("annul_idle", {31'b0, busy_o}, 32'd0);
        check("annul_ready", {31'b0, ready_o}, 32'd0);
        check("annul_result_kept", result_o, 32'd5);
        run_op(1'b0, 1'b0, 32'd9,         32'd3,         32'd3,         1'b0, 33);

        // Dividend smaller than divisor.
        run_op(1'b0, 1'b0, 32'd3,         32'd10,        32'd0,         1'b0, EO_LAT);
        run_op(1'b0, 1'b1, 32'd3,         32'd10,        32'd3,         1'b0, EO_LAT);

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
